// File: rtl/aes_key_expand_round.sv
// One AES-128 key-schedule step: next round key from the current key and Rcon,
// registered with a single cycle of latency.
module aes_key_expand_round (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic [7:0]   rnd_constant,
  output logic [127:0] key_out
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Four parallel table lookups, one per byte lane.
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  logic [31:0]  w0_p0, w1_p0, w2_p0, w3_p0;
  logic [31:0]  t_p0, w4_p0, w5_p0, w6_p0, w7_p0;
  logic [127:0] key_p1;

  always_comb begin
    w0_p0 = key_in[127:96];
    w1_p0 = key_in[95:64];
    w2_p0 = key_in[63:32];
    w3_p0 = key_in[31:0];
    t_p0  = sub_word(rot_word(w3_p0)) ^ {rnd_constant, 24'h0};
    w4_p0 = w0_p0 ^ t_p0;
    w5_p0 = w1_p0 ^ w4_p0;
    w6_p0 = w2_p0 ^ w5_p0;
    w7_p0 = w3_p0 ^ w6_p0;
  end

  // p0 -> p1: the only register stage; clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) key_p1 <= '0;
    else     key_p1 <= {w4_p0, w5_p0, w6_p0, w7_p0};
  end

  assign key_out = key_p1;

endmodule

// File: tb/tb_aes_key_expand_round.sv
// Bench for aes_key_expand_round: known-answer vectors through a scoreboard
// queue, plus asynchronous-reset sequences.
module tb_aes_key_expand_round;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic [7:0]   rnd_constant = '0;
  logic [127:0] key_out;

  aes_key_expand_round dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .rnd_constant (rnd_constant),
    .key_out      (key_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [7:0]   rcon;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: key_out=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, queue the expectation, compare just after the rising edge.
  task automatic apply(input string name, input logic [127:0] key, input logic [7:0] rcon,
                       input logic [127:0] exp);
    @(negedge clk);
    key_in       = key;
    rnd_constant = rcon;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, key_out, sb.pop_front());
    end
  endtask

  initial begin
    vecs.push_back('{"nist_ecb", 128'h6bc1bee22e409f96e93d7e117393172a, 8'h01, 128'hb6315b6d9871c4fb714cbaea02dfadc0});
    vecs.push_back('{"fips_r1",  128'h2b7e151628aed2a6abf7158809cf4f3c, 8'h01, 128'ha0fafe1788542cb123a339392a6c7605});
    vecs.push_back('{"fips_r2",  128'ha0fafe1788542cb123a339392a6c7605, 8'h02, 128'hf2c295f27a96b9435935807a7359f67f});
    vecs.push_back('{"fips_r3",  128'hf2c295f27a96b9435935807a7359f67f, 8'h04, 128'h3d80477d4716fe3e1e237e446d7a883b});
    vecs.push_back('{"fips_r4",  128'h3d80477d4716fe3e1e237e446d7a883b, 8'h08, 128'hef44a541a8525b7fb671253bdb0bad00});
    vecs.push_back('{"fips_r5",  128'hef44a541a8525b7fb671253bdb0bad00, 8'h10, 128'hd4d1c6f87c839d87caf2b8bc11f915bc});
    vecs.push_back('{"fips_r6",  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 8'h20, 128'h6d88a37a110b3efddbf98641ca0093fd});
    vecs.push_back('{"fips_r7",  128'h6d88a37a110b3efddbf98641ca0093fd, 8'h40, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f});
    vecs.push_back('{"fips_r8",  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 8'h80, 128'head27321b58dbad2312bf5607f8d292f});
    vecs.push_back('{"fips_r9",  128'head27321b58dbad2312bf5607f8d292f, 8'h1b, 128'hac7766f319fadc2128d12941575c006e});
    vecs.push_back('{"fips_r10", 128'hac7766f319fadc2128d12941575c006e, 8'h36, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    vecs.push_back('{"zero_rc1", 128'h0, 8'h01, 128'h62636363626363636263636362636363});
    vecs.push_back('{"zero_rc0", 128'h0, 8'h00, 128'h63636363636363636363636363636363});
    vecs.push_back('{"zero_rcff", 128'h0, 8'hff, 128'h9c6363639c6363639c6363639c636363});

    // Reset held: output stays cleared across clock edges with garbage inputs.
    key_in       = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    rnd_constant = 8'h5a;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", key_out, 128'h0);

    // Release with inputs held: first edge loads f(key_in, rcon); unsized 1 is Rcon 01.
    @(negedge clk);
    key_in       = 128'h6bc1bee22e409f96e93d7e117393172a;
    rnd_constant = 1;
    rst          = 1'b0;
    sb.push_back(128'hb6315b6d9871c4fb714cbaea02dfadc0);
    @(posedge clk);
    #1;
    check("reset_release", key_out, sb.pop_front());

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].key, vecs[i].rcon, vecs[i].exp);

    // Held input: output stays stable edge after edge.
    apply("hold_a", 128'h2b7e151628aed2a6abf7158809cf4f3c, 8'h01, 128'ha0fafe1788542cb123a339392a6c7605);
    apply("hold_b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 8'h01, 128'ha0fafe1788542cb123a339392a6c7605);

    // Mid-run reset: clears without a clock edge, holds, then reloads on release.
    #1 rst = 1'b1;
    #1 check("async_clear", key_out, 128'h0);
    @(posedge clk);
    #1 check("reset_hold", key_out, 128'h0);
    @(negedge clk);
    key_in       = 128'hac7766f319fadc2128d12941575c006e;
    rnd_constant = 8'h36;
    rst          = 1'b0;
    sb.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge clk);
    #1;
    check("post_reset", key_out, sb.pop_front());

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, 0 expected", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
